// File: rtl/prio_grant_arb.sv
// Eight-requester grant controller: leading-one priority pick, hold until done or
// MAX_HOLD timeout, one-cycle recovery gap. Define ARB_RR_EN for round-robin fairness.
module prio_grant_arb #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RECOVER = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t     state, state_next;
    logic [7:0] gnt_next;
    logic [2:0] gnt_id_next;
    logic       timeout_next;
    logic [7:0] hold_cnt, hold_cnt_next;
    logic [2:0] ptr, ptr_next;
    logic [2:0] cand;
    logic [2:0] win_id;
    logic       found;

    // Id k lives at req[7-k]; scan ids ptr, ptr+1, ... wrapping mod 8.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && req[3'd7 - cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    always_comb begin
        state_next    = state;
        gnt_next      = gnt;
        gnt_id_next   = gnt_id;
        timeout_next  = 1'b0;
        hold_cnt_next = hold_cnt;
        ptr_next      = ptr;
        case (state)
            IDLE: begin
                gnt_next = '0;
                if (found) begin
                    state_next    = GRANT;
                    gnt_next      = 8'h80 >> win_id;
                    gnt_id_next   = win_id;
                    hold_cnt_next = '0;
`ifdef ARB_RR_EN
                    ptr_next      = win_id + 3'd1;
`endif
                end
            end
            GRANT: begin
                if (done) begin
                    state_next = RECOVER;
                    gnt_next   = '0;
                end else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
                    state_next   = RECOVER;
                    gnt_next     = '0;
                    timeout_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt + 8'd1;
                end
            end
            RECOVER: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_next;
            gnt      <= gnt_next;
            gnt_id   <= gnt_id_next;
            timeout  <= timeout_next;
            hold_cnt <= hold_cnt_next;
            ptr      <= ptr_next;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_prio_grant_arb.sv
// Self-checking bench for prio_grant_arb with a transaction-level reference model.
module tb_prio_grant_arb;

    localparam int MAX_HOLD = 4;

    logic       clock;
    logic       reset_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 idle, 1 granted, 2 recovering
    int         m_phase;
    int         m_held;
    int         m_ptr;
    logic [7:0] m_gnt;
    logic [2:0] m_id;
    logic       m_to;

    prio_grant_arb #(.MAX_HOLD(MAX_HOLD)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [13:0] expected();
        return {m_gnt, m_id, (m_phase != 0), m_to};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_held = 0; m_ptr = 0;
        m_gnt = '0; m_id = '0; m_to = 1'b0;
    endtask

    task automatic model_edge();
        int winner;
        case (m_phase)
            0: begin
                m_to  = 1'b0;
                m_gnt = '0;
                if (req != 8'h00) begin
                    winner = -1;
                    for (int k = 0; k < 8; k++) begin
                        int id;
                        id = (m_ptr + k) % 8;
                        if (winner < 0 && req[7 - id]) winner = id;
                    end
                    m_gnt   = 8'(1 << (7 - winner));
                    m_id    = 3'(winner);
                    m_held  = 1;
                    m_phase = 1;
`ifdef ARB_RR_EN
                    m_ptr = (winner + 1) % 8;
`endif
                end
            end
            1: begin
                if (done) begin
                    m_phase = 2; m_gnt = '0; m_to = 1'b0;
                end else if (m_held == MAX_HOLD) begin
                    m_phase = 2; m_gnt = '0; m_to = 1'b1;
                end else begin
                    m_held++;
                end
            end
            default: begin
                m_phase = 0; m_gnt = '0; m_to = 1'b0;
            end
        endcase
    endtask

    task automatic clk_step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        model_reset();
        req = '0; done = 1'b0;
        #10;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        req = 8'h80;
        clk_step();
        n_checks++;
        if ({gnt, gnt_id, busy} !== {8'h80, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_pre_grant: got gnt=%h id=%0d busy=%b want gnt=80 id=0 busy=1", gnt, gnt_id, busy);
        end
        clk_step();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({gnt, gnt_id, busy, timeout} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_async: got gnt=%h id=%0d busy=%b to=%b want all zero", gnt, gnt_id, busy, timeout);
        end
        req = 8'h00;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            n_checks++;
            if ({gnt, gnt_id, busy, timeout} !== 13'h0) begin
                n_fail++;
                $display("FAIL reset_idle_stay: got gnt=%h id=%0d busy=%b to=%b want all zero", gnt, gnt_id, busy, timeout);
            end
        end
    endtask

    task automatic test_fixed_priority();
        int spacing;
        do_reset();
        req = 8'h05;
        clk_step();
        n_checks++;
        if ({gnt, gnt_id} !== {8'h04, 3'd5}) begin
            n_fail++;
            $display("FAIL prio_05: got gnt=%h id=%0d want gnt=04 id=5", gnt, gnt_id);
        end
        done = 1'b1;
        clk_step();
        done = 1'b0;
        spacing = 0;
        for (int i = 0; i < 4 && gnt == 8'h00; i++) begin
            clk_step();
            spacing++;
        end
        n_checks++;
        if (spacing != 2 || {gnt, gnt_id, busy, timeout} !== expected()) begin
            n_fail++;
            $display("FAIL prio_regrant: got spacing=%0d gnt=%h id=%0d want spacing=2 gnt=%h id=%0d",
                     spacing, gnt, gnt_id, m_gnt, m_id);
        end
        do_reset();
        req = 8'hFF;
        clk_step();
        n_checks++;
        if ({gnt, gnt_id} !== {8'h80, 3'd0}) begin
            n_fail++;
            $display("FAIL prio_ff: got gnt=%h id=%0d want gnt=80 id=0", gnt, gnt_id);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            done = 1'b0;
            clk_step();
            n_checks++;
            if ({gnt, gnt_id, busy, timeout} !== expected()) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got gnt=%h id=%0d want gnt=%h id=%0d", g, gnt, gnt_id, m_gnt, m_id);
            end
            done = 1'b1;
            clk_step();
            done = 1'b0;
            clk_step();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req  = 8'h01;
        done = 1'b0;
        for (int c = 0; c < MAX_HOLD; c++) begin
            clk_step();
            n_checks++;
            if ({gnt, gnt_id, busy, timeout} !== {8'h01, 3'd7, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout_hold%0d: got gnt=%h id=%0d busy=%b to=%b want gnt=01 id=7 busy=1 to=0",
                         c, gnt, gnt_id, busy, timeout);
            end
        end
        req = 8'h00;
        clk_step();
        n_checks++;
        if ({gnt, busy, timeout} !== {8'h00, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_pulse: got gnt=%h busy=%b to=%b want gnt=00 busy=1 to=1", gnt, busy, timeout);
        end
        clk_step();
        n_checks++;
        if ({gnt, busy, timeout} !== {8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_idle: got gnt=%h busy=%b to=%b want gnt=00 busy=0 to=0", gnt, busy, timeout);
        end
    endtask

    task automatic test_collision();
        do_reset();
        req = 8'h10;
        clk_step();
        for (int c = 1; c < MAX_HOLD; c++) clk_step();
        done = 1'b1;
        clk_step();
        done = 1'b0;
        req  = 8'h00;
        n_checks++;
        if ({gnt, busy, timeout} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL collision: got gnt=%h busy=%b to=%b want gnt=00 busy=1 to=0", gnt, busy, timeout);
        end
    endtask

    task automatic test_spurious_done();
        do_reset();
        done = 1'b1;
        req  = 8'h00;
        clk_step();
        clk_step();
        req = 8'h20;
        clk_step();
        done = 1'b0;
        req  = 8'h00;
        for (int c = 0; c < 2; c++) begin
            clk_step();
            n_checks++;
            if ({gnt, gnt_id, busy} !== {8'h20, 3'd2, 1'b1}) begin
                n_fail++;
                $display("FAIL spurious_hold%0d: got gnt=%h id=%0d busy=%b want gnt=20 id=2 busy=1",
                         c, gnt, gnt_id, busy);
            end
        end
        done = 1'b1;
        clk_step();
        clk_step();
        done = 1'b0;
        n_checks++;
        if ({gnt, gnt_id, busy, timeout} !== {8'h00, 3'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL spurious_recover: got gnt=%h id=%0d busy=%b to=%b want gnt=00 id=2 busy=0 to=0",
                     gnt, gnt_id, busy, timeout);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            done = ($urandom_range(0, 3) == 0);
            clk_step();
            n_checks++;
            if ({gnt, gnt_id, busy, timeout} !== expected()) begin
                n_fail++;
                $display("FAIL random_c%0d: got gnt=%h id=%0d busy=%b to=%b want gnt=%h id=%0d busy=%b to=%b",
                         c, gnt, gnt_id, busy, timeout, m_gnt, m_id, (m_phase != 0), m_to);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        done    = 1'b0;
        model_reset();
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_timeout();
        test_collision();
        test_spurious_done();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
